// File: rtl/if_stage_fetch_pkg.sv
// Shared pipeline constants: word geometry, bubble encoding, reset PC and
// the fetch-stage state encoding reused by the downstream stage registers.
package if_stage_fetch_pkg;

    localparam int                 WORD_W         = 32;
    localparam logic [WORD_W-1:0]  WORD_BYTES     = 32'd4;
    localparam logic [WORD_W-1:0]  PIPE_NOP_INSTR = 32'h0000_0000;
    localparam logic [WORD_W-1:0]  PIPE_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_stage_fetch_id_reg.sv
// IF/ID pipeline register: hold keeps contents, flush inserts a bubble,
// load captures a real instruction. Priority is hold > flush > load.
module if_id_reg
    import if_stage_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = PIPE_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              load,
    input  logic [WORD_W-1:0] instr_d,
    input  logic [WORD_W-1:0] pc_d,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_out,
    output logic              valid_out
);

    // A bubble keeps the last pc_out so decode still has a defined PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            valid_out   <= 1'b0;
        end else if (!hold) begin
            if (flush) begin
                instruction <= NOP_INSTR;
                valid_out   <= 1'b0;
            end else if (load) begin
                instruction <= instr_d;
                pc_out      <= pc_d;
                valid_out   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC, request/ack memory port, one-entry skid
// buffer for freezes, branch redirect/squash, feeding the IF/ID register.
module if_stage_fetch
    import if_stage_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = PIPE_RESET_PC,
    parameter logic [WORD_W-1:0] NOP_INSTR = PIPE_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_offset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_out,
    output logic              valid_out
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] skid;
    logic [WORD_W-1:0] redirect_pc;
    logic              redirect_pending;

    logic              br_eff;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] pc_inc;
    logic              ifid_flush;
    logic              ifid_load;
    logic [WORD_W-1:0] ifid_instr;

    // Decode suppresses branches during a hazard, so freeze masks br_taken.
    assign br_eff    = br_taken && !freeze;
    assign target    = pc_out + {br_offset[WORD_W-3:0], 2'b00};
    assign pc_inc    = pc_reg + WORD_BYTES;
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc_reg;

    always_comb begin
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        ifid_instr = imem_rdata;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_pending || br_eff) ifid_flush = 1'b1;
                    else if (!freeze)               ifid_load  = 1'b1;
                end else if (!freeze) begin
                    ifid_flush = 1'b1;
                end
            end
            HOLD: begin
                ifid_instr = skid;
                if (!freeze) begin
                    if (br_taken) ifid_flush = 1'b1;
                    else          ifid_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Fetch control: a request is never aborted, so a branch seen mid-request
    // is parked in redirect_pc and applied when the ack finally arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            pc_reg           <= RESET_PC;
            skid             <= NOP_INSTR;
            redirect_pc      <= RESET_PC;
            redirect_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect_pending || br_eff) begin
                            pc_reg           <= br_eff ? target : redirect_pc;
                            redirect_pending <= 1'b0;
                        end else if (!freeze) begin
                            pc_reg <= pc_inc;
                        end else begin
                            skid  <= imem_rdata;
                            state <= HOLD;
                        end
                    end else if (br_eff) begin
                        redirect_pending <= 1'b1;
                        redirect_pc      <= target;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        pc_reg <= br_taken ? target : pc_inc;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .hold        (freeze),
        .flush       (ifid_flush),
        .load        (ifid_load),
        .instr_d     (ifid_instr),
        .pc_d        (pc_inc),
        .instruction (instruction),
        .pc_out      (pc_out),
        .valid_out   (valid_out)
    );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: table-driven zero-wait vectors plus directed
// sequences for slow memory, outstanding-request branches, reset and PC wrap.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int mem_lat   = 0;
    int wait_cnt;

    localparam logic [31:0] NOP = 32'h0000_0000;

    if_stage_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_out      (pc_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory model: ack after mem_lat extra cycles of a held request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req)             wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt == mem_lat);
    assign imem_rdata = imem_ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] off;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] off,
                                input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                                input logic req, input logic [31:0] addr);
        vec_t v;
        v.frz = frz; v.br = br; v.off = off; v.vld = vld;
        v.instr = instr; v.pc = pc; v.req = req; v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_offset = '0; mem_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int nvalid;
        int found;
        logic [31:0] exp_pc;

        vecs[0]  = mk(0, 0, 0, 0, NOP,                  32'h00, 1, 32'h00);
        vecs[1]  = mk(0, 0, 0, 1, instr_of(32'h00),     32'h04, 1, 32'h04);
        vecs[2]  = mk(0, 0, 0, 1, instr_of(32'h04),     32'h08, 1, 32'h08);
        vecs[3]  = mk(0, 0, 0, 1, instr_of(32'h08),     32'h0C, 1, 32'h0C);
        vecs[4]  = mk(0, 0, 0, 1, instr_of(32'h0C),     32'h10, 1, 32'h10);
        vecs[5]  = mk(0, 1, 3, 0, NOP,                  32'h10, 1, 32'h1C);
        vecs[6]  = mk(0, 0, 0, 1, instr_of(32'h1C),     32'h20, 1, 32'h20);
        vecs[7]  = mk(0, 0, 0, 1, instr_of(32'h20),     32'h24, 1, 32'h24);
        vecs[8]  = mk(1, 0, 0, 1, instr_of(32'h20),     32'h24, 0, 32'h24);
        vecs[9]  = mk(1, 0, 0, 1, instr_of(32'h20),     32'h24, 0, 32'h24);
        vecs[10] = mk(1, 0, 0, 1, instr_of(32'h20),     32'h24, 0, 32'h24);
        vecs[11] = mk(0, 0, 0, 1, instr_of(32'h24),     32'h28, 1, 32'h28);
        vecs[12] = mk(0, 0, 0, 1, instr_of(32'h28),     32'h2C, 1, 32'h2C);
        vecs[13] = mk(1, 1, 5, 1, instr_of(32'h28),     32'h2C, 0, 32'h2C);
        vecs[14] = mk(1, 1, 5, 1, instr_of(32'h28),     32'h2C, 0, 32'h2C);
        vecs[15] = mk(0, 0, 0, 1, instr_of(32'h2C),     32'h30, 1, 32'h30);
        vecs[16] = mk(0, 0, 0, 1, instr_of(32'h30),     32'h34, 1, 32'h34);

        // Reset values, then zero-wait streaming, branch, freeze, freeze+branch
        rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_offset = '0; mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_instr", instruction, NOP);
        chk("reset_pc_out", pc_out, 32'd0);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_addr", imem_addr, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            freeze = vecs[i].frz; br_taken = vecs[i].br; br_offset = vecs[i].off;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, vecs[i].vld});
            chk($sformatf("vec%0d_instr", i), instruction, vecs[i].instr);
            chk($sformatf("vec%0d_pc_out", i), pc_out, vecs[i].pc);
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
        end

        // Two-cycle memory: bubbles between instructions, none skipped/repeated
        do_reset(1);
        nvalid = 0;
        exp_pc = 32'h4;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid_out) begin
                chk("slow_pc_out", pc_out, exp_pc);
                chk("slow_instr", instruction, instr_of(exp_pc - 32'h4));
                exp_pc = exp_pc + 32'h4;
                nvalid++;
            end
        end
        chk("slow_valid_count", nvalid, 5);

        // Branch during an outstanding 3-cycle request, target 0x40
        do_reset(2);
        repeat (4) step();
        chk("outst_pre_valid", {31'd0, valid_out}, 32'd1);
        chk("outst_pre_pc", pc_out, 32'h4);
        br_taken = 1'b1; br_offset = 32'd15;
        step();
        br_taken = 1'b0; br_offset = '0;
        chk("outst_sq_valid", {31'd0, valid_out}, 32'd0);
        chk("outst_addr_stable", imem_addr, 32'h4);
        chk("outst_req_held", {31'd0, imem_req}, 32'd1);
        step();
        chk("outst_sq2_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk("outst_drop_valid", {31'd0, valid_out}, 32'd0);
        chk("outst_new_addr", imem_addr, 32'h40);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (valid_out) found = 1;
        end
        chk("outst_found", found, 1);
        chk("outst_first_pc", pc_out, 32'h44);
        chk("outst_first_instr", instruction, instr_of(32'h40));

        // Async reset mid-request, then restart from RESET_PC
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        chk("midrst_instr", instruction, NOP);
        chk("midrst_pc_out", pc_out, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'd0);
        step();
        chk("restart_valid", {31'd0, valid_out}, 32'd1);
        chk("restart_pc_out", pc_out, 32'h4);

        // Negative-offset branch to 0xFFFF_FFFC, then PC wraps to 0
        br_taken = 1'b1; br_offset = 32'hFFFF_FFFE;
        step();
        br_taken = 1'b0; br_offset = '0;
        chk("wrap_branch_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_branch_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk("wrap_valid", {31'd0, valid_out}, 32'd1);
        chk("wrap_pc_out", pc_out, 32'h0);
        chk("wrap_instr", instruction, instr_of(32'hFFFF_FFFC));
        chk("wrap_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
